// File: rtl/uart_baud_gen_frac.sv
// Fractional oversampling baud-rate generator: oversample, mid-bit and bit strobes
// with glitch-free divisor reload and synchronous phase-align clear.
module uart_baud_gen_frac #(
  parameter int INT_WIDTH     = 16,
  parameter int FRAC_WIDTH    = 4,
  parameter int OS_RATE       = 16,
  parameter int RESET_DIV_INT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_clear,
  input  logic [INT_WIDTH-1:0]  i_div_int,
  input  logic [FRAC_WIDTH-1:0] i_div_frac,
  input  logic                  i_div_load,
  output logic                  o_os_tick,
  output logic                  o_mid_tick,
  output logic                  o_bit_tick,
  output logic                  o_div_err
);

  localparam int OS_W = $clog2(OS_RATE);
  localparam logic [INT_WIDTH-1:0]  INT_ZERO  = {INT_WIDTH{1'b0}};
  localparam logic [INT_WIDTH-1:0]  INT_ONE   = INT_WIDTH'(1);
  localparam logic [INT_WIDTH-1:0]  INT_RST   = INT_WIDTH'(RESET_DIV_INT);
  localparam logic [FRAC_WIDTH-1:0] FRAC_ZERO = {FRAC_WIDTH{1'b0}};
  localparam logic [OS_W-1:0]       OS_ZERO   = {OS_W{1'b0}};
  localparam logic [OS_W-1:0]       OS_ONE    = OS_W'(1);
  localparam logic [OS_W-1:0]       OS_LAST   = OS_W'(OS_RATE - 1);
  localparam logic [OS_W-1:0]       OS_MID    = OS_W'(OS_RATE / 2 - 1);

  logic [INT_WIDTH-1:0]  cyc_cnt_r, cyc_cnt_nxt_s;
  logic [FRAC_WIDTH-1:0] frac_acc_r, frac_acc_nxt_s;
  logic                  ext_r, ext_nxt_s;
  logic [OS_W-1:0]       os_cnt_r, os_cnt_nxt_s;
  logic [INT_WIDTH-1:0]  active_int_r, active_int_nxt_s;
  logic [FRAC_WIDTH-1:0] active_frac_r, active_frac_nxt_s;
  logic [INT_WIDTH-1:0]  pend_int_r, pend_int_nxt_s;
  logic [FRAC_WIDTH-1:0] pend_frac_r, pend_frac_nxt_s;
  logic                  pend_flag_r, pend_flag_nxt_s;
  logic                  os_tick_r, os_tick_nxt_s;
  logic                  mid_tick_r, mid_tick_nxt_s;
  logic                  bit_tick_r, bit_tick_nxt_s;
  logic                  div_err_r, div_err_nxt_s;

  logic [INT_WIDTH-1:0]  term_s;
  logic [FRAC_WIDTH:0]   frac_sum_s;
  logic                  hold_s, os_event_s, apply_s;

  // A zero divisor parks the counters; parking is also an apply point so a reload recovers.
  assign hold_s     = div_err_r | (active_int_r == INT_ZERO);
  assign term_s     = active_int_r - INT_ONE + INT_WIDTH'(ext_r);
  assign frac_sum_s = {1'b0, frac_acc_r} + {1'b0, active_frac_r};
  assign os_event_s = i_en & ~i_clear & ~hold_s & (cyc_cnt_r == term_s);
  assign apply_s    = i_clear | ~i_en | os_event_s | hold_s;

  // Next-state for phase counters, tick strobes and the divisor shadow registers.
  always_comb begin
    cyc_cnt_nxt_s     = cyc_cnt_r;
    frac_acc_nxt_s    = frac_acc_r;
    ext_nxt_s         = ext_r;
    os_cnt_nxt_s      = os_cnt_r;
    active_int_nxt_s  = active_int_r;
    active_frac_nxt_s = active_frac_r;
    pend_int_nxt_s    = pend_int_r;
    pend_frac_nxt_s   = pend_frac_r;
    pend_flag_nxt_s   = pend_flag_r;
    os_tick_nxt_s     = 1'b0;
    mid_tick_nxt_s    = 1'b0;
    bit_tick_nxt_s    = 1'b0;

    if (i_clear || (i_en && hold_s)) begin
      cyc_cnt_nxt_s  = INT_ZERO;
      os_cnt_nxt_s   = OS_ZERO;
      frac_acc_nxt_s = FRAC_ZERO;
      ext_nxt_s      = 1'b0;
    end else if (!i_en) begin
      cyc_cnt_nxt_s  = cyc_cnt_r;
    end else if (os_event_s) begin
      cyc_cnt_nxt_s                = INT_ZERO;
      {ext_nxt_s, frac_acc_nxt_s}  = frac_sum_s;
      os_cnt_nxt_s                 = (os_cnt_r == OS_LAST) ? OS_ZERO : os_cnt_r + OS_ONE;
      os_tick_nxt_s                = 1'b1;
      mid_tick_nxt_s               = (os_cnt_r == OS_MID);
      bit_tick_nxt_s               = (os_cnt_r == OS_LAST);
    end else begin
      cyc_cnt_nxt_s  = cyc_cnt_r + INT_ONE;
    end

    if (i_div_load) begin
      pend_int_nxt_s  = i_div_int;
      pend_frac_nxt_s = i_div_frac;
      if (apply_s) begin
        active_int_nxt_s  = i_div_int;
        active_frac_nxt_s = i_div_frac;
        pend_flag_nxt_s   = 1'b0;
      end else begin
        pend_flag_nxt_s   = 1'b1;
      end
    end else if (apply_s && pend_flag_r) begin
      active_int_nxt_s  = pend_int_r;
      active_frac_nxt_s = pend_frac_r;
      pend_flag_nxt_s   = 1'b0;
    end else begin
      pend_flag_nxt_s   = pend_flag_r;
    end

    div_err_nxt_s = (active_int_nxt_s == INT_ZERO);
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cyc_cnt_r     <= INT_ZERO;
      frac_acc_r    <= FRAC_ZERO;
      ext_r         <= 1'b0;
      os_cnt_r      <= OS_ZERO;
      active_int_r  <= INT_RST;
      active_frac_r <= FRAC_ZERO;
      pend_int_r    <= INT_ZERO;
      pend_frac_r   <= FRAC_ZERO;
      pend_flag_r   <= 1'b0;
      os_tick_r     <= 1'b0;
      mid_tick_r    <= 1'b0;
      bit_tick_r    <= 1'b0;
      div_err_r     <= 1'b0;
    end else begin
      cyc_cnt_r     <= cyc_cnt_nxt_s;
      frac_acc_r    <= frac_acc_nxt_s;
      ext_r         <= ext_nxt_s;
      os_cnt_r      <= os_cnt_nxt_s;
      active_int_r  <= active_int_nxt_s;
      active_frac_r <= active_frac_nxt_s;
      pend_int_r    <= pend_int_nxt_s;
      pend_frac_r   <= pend_frac_nxt_s;
      pend_flag_r   <= pend_flag_nxt_s;
      os_tick_r     <= os_tick_nxt_s;
      mid_tick_r    <= mid_tick_nxt_s;
      bit_tick_r    <= bit_tick_nxt_s;
      div_err_r     <= div_err_nxt_s;
    end
  end

  assign o_os_tick  = os_tick_r;
  assign o_mid_tick = mid_tick_r;
  assign o_bit_tick = bit_tick_r;
  assign o_div_err  = div_err_r;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac: per-cycle vector table plus multi-cycle
// period measurements for fraction, reload, freeze, clear, error and reset cases.
module tb_uart_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, clr, ld;
  logic [15:0] di;
  logic [3:0]  df;
  logic        os_t, mid_t, bit_t, err;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  uart_baud_gen_frac #(
    .INT_WIDTH(16), .FRAC_WIDTH(4), .OS_RATE(16), .RESET_DIV_INT(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clear(clr),
    .i_div_int(di), .i_div_frac(df), .i_div_load(ld),
    .o_os_tick(os_t), .o_mid_tick(mid_t), .o_bit_tick(bit_t), .o_div_err(err)
  );

  typedef struct {
    logic        en, clr, ld;
    logic [15:0] di;
    logic [3:0]  df;
    logic        os, mid, bt, err;
  } vec_t;

  vec_t tbl[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic l,
                       input logic [15:0] vi, input logic [3:0] vf);
    en = e; clr = c; ld = l; di = vi; df = vf;
  endtask

  task automatic set_vec(input int i, input logic e, input logic c, input logic l,
                         input logic [15:0] vi, input logic [3:0] vf,
                         input logic eo, input logic em, input logic eb, input logic ee);
    tbl[i].en = e; tbl[i].clr = c; tbl[i].ld = l; tbl[i].di = vi; tbl[i].df = vf;
    tbl[i].os = eo; tbl[i].mid = em; tbl[i].bt = eb; tbl[i].err = ee;
  endtask

  // Steps until o_os_tick is seen; n is the number of edges taken.
  task automatic wait_tick(input int max_cyc, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < max_cyc) begin
      step();
      n++;
      if (os_t) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: no os tick within %0d cycles", max_cyc);
      n = -1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sum, seen, exp_p;

    // N=1 runs one os event per edge, so mid lands on vector 8 and bit on 16.
    set_vec(0, 1'b1, 1'b1, 1'b1, 16'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++)
      set_vec(i, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b1, (i == 8), (i == 16), 1'b0);
    set_vec(17, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_vec(18, 1'b1, 1'b0, 1'b1, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    set_vec(19, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    set_vec(20, 1'b1, 1'b0, 1'b1, 16'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_vec(21, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_vec(22, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_vec(23, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_vec(24, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_vec(25, 1'b1, 1'b1, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'd0, 4'd0);
    repeat (3) step();
    check("rst_os", 32'(os_t), 32'd0);
    check("rst_mid", 32'(mid_t), 32'd0);
    check("rst_bit", 32'(bit_t), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_os", 32'(os_t), 32'd0);

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].ld, tbl[i].di, tbl[i].df);
      step();
      check($sformatf("vec%0d_os", i), 32'(os_t), 32'(tbl[i].os));
      check($sformatf("vec%0d_mid", i), 32'(mid_t), 32'(tbl[i].mid));
      check($sformatf("vec%0d_bit", i), 32'(bit_t), 32'(tbl[i].bt));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].err));
    end

    // Integer divide by 4.
    drive(1'b1, 1'b1, 1'b1, 16'd4, 4'd0); step();
    drive(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    sum = 0;
    for (int k = 1; k <= 32; k++) begin
      wait_tick(20, n);
      sum += n;
      check($sformatf("int_period_%0d", k), 32'(n), 32'd4);
      check($sformatf("int_mid_%0d", k), 32'(mid_t), 32'((k % 16) == 8));
      check($sformatf("int_bit_%0d", k), 32'(bit_t), 32'((k % 16) == 0));
      if (k == 16) check("int_bit_cycle", 32'(sum), 32'd64);
    end

    // Fractional divide 4.5: periods 4,4,5,4,5,...
    drive(1'b1, 1'b1, 1'b1, 16'd4, 4'd8); step();
    drive(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    sum = 0;
    for (int k = 1; k <= 33; k++) begin
      wait_tick(20, n);
      exp_p = (k >= 3 && (k % 2) == 1) ? 5 : 4;
      check($sformatf("frac_period_%0d", k), 32'(n), 32'(exp_p));
      if (k >= 2) sum += n;
    end
    check("frac_32_periods", 32'(sum), 32'd144);

    // Reload mid-period: N=10 period completes, then N=3.
    drive(1'b1, 1'b1, 1'b1, 16'd10, 4'd0); step();
    drive(1'b1, 1'b0, 1'b0, 16'd0, 4'd0); step(); step();
    drive(1'b1, 1'b0, 1'b1, 16'd3, 4'd0); step();
    drive(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    wait_tick(30, n);
    check("reload_old_period", 32'(n + 3), 32'd10);
    for (int k = 0; k < 3; k++) begin
      wait_tick(20, n);
      check("reload_new_period", 32'(n), 32'd3);
    end
    drive(1'b0, 1'b0, 1'b1, 16'd5, 4'd0); step();
    check("load_dis_no_tick", 32'(os_t), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    wait_tick(20, n);
    check("load_dis_applied", 32'(n), 32'd5);

    // Enable freeze at cyc_cnt=5 of N=8.
    drive(1'b1, 1'b1, 1'b1, 16'd8, 4'd0); step();
    drive(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    repeat (5) step();
    drive(1'b0, 1'b0, 1'b0, 16'd0, 4'd0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (os_t || mid_t || bit_t) seen++;
    end
    check("freeze_no_ticks", 32'(seen), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    wait_tick(20, n);
    check("freeze_resume", 32'(n), 32'd3);

    // Clear plus load N=6 while os_cnt=11.
    drive(1'b1, 1'b1, 1'b1, 16'd2, 4'd0); step();
    drive(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    for (int k = 0; k < 11; k++) wait_tick(10, n);
    step();
    drive(1'b1, 1'b1, 1'b1, 16'd6, 4'd0); step();
    check("clrld_no_tick", 32'(os_t), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    for (int k = 1; k <= 16; k++) begin
      wait_tick(20, n);
      check($sformatf("clrld_period_%0d", k), 32'(n), 32'd6);
      check($sformatf("clrld_mid_%0d", k), 32'(mid_t), 32'(k == 8));
      check($sformatf("clrld_bit_%0d", k), 32'(bit_t), 32'(k == 16));
    end

    // Zero divisor error and recovery.
    drive(1'b0, 1'b0, 1'b1, 16'd0, 4'd0); step();
    check("err_set", 32'(err), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (os_t || mid_t || bit_t) seen++;
    end
    check("err_no_ticks", 32'(seen), 32'd0);
    check("err_held", 32'(err), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 16'd2, 4'd0); step();
    check("err_clear", 32'(err), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    wait_tick(10, n);
    check("err_recover_1", 32'(n), 32'd2);
    wait_tick(10, n);
    check("err_recover_2", 32'(n), 32'd2);

    // Async reset while o_os_tick is high.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_os", 32'(os_t), 32'd0);
    check("arst_mid", 32'(mid_t), 32'd0);
    check("arst_bit", 32'(bit_t), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(10, n);
    check("arst_div1_a", 32'(n), 32'd1);
    wait_tick(10, n);
    check("arst_div1_b", 32'(n), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 16'd0, 4'd0); step();
    check("arst_err_pre", 32'(err), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 16'd0, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_err_drop", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen_frac.md
# uart_baud_gen_frac

Fractional, oversampling baud-rate generator for the UART RX/TX datapaths. It replaces the integer-only divider. It produces three one-cycle strobes: an oversample tick with a fractional average period, a mid-bit sample tick and a bit tick. Divisor updates are glitch-free, and a synchronous clear phase-aligns the generator to a detected start bit.

## Interface
- INT_WIDTH, 16: width of the integer divisor.
- FRAC_WIDTH, 4: width of the fractional divisor. The fraction is i_div_frac / 2^FRAC_WIDTH.
- OS_RATE, 16: oversample ticks per bit. Must be even and ≥ 4.
- RESET_DIV_INT, 1: active integer divisor after reset. The active fraction resets to 0.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  count enable. When low, all counters hold and all ticks stay low.
- i_clear  in  1  synchronous restart and phase align
- i_div_int  in  INT_WIDTH  new integer divisor
- i_div_frac  in  FRAC_WIDTH  new fractional divisor
- i_div_load  in  1  one-cycle strobe that captures i_div_int and i_div_frac
- o_os_tick  out  1  oversample strobe
- o_mid_tick  out  1  strobe at the middle sample point of each bit
- o_bit_tick  out  1  strobe at the end of each bit
- o_div_err  out  1  high while the active integer divisor is 0

## Operation
- State:
  - cyc_cnt [INT_WIDTH]
  - frac_acc [FRAC_WIDTH]
  - ext: 1 = current oversample period is one cycle longer
  - os_cnt [$clog2(OS_RATE)]
  - active_int / active_frac
  - pend_int / pend_frac / pend_flag
- Terminal count: term = active_int − 1 + ext.
- Counting: each edge with i_en=1, i_clear=0 and o_div_err=0:
  - If cyc_cnt ≠ term: cyc_cnt increments.
  - If cyc_cnt == term (os event): cyc_cnt ← 0, {ext, frac_acc} ← frac_acc + active_frac, os_cnt ← os_cnt + 1 modulo OS_RATE.
- Average oversample period: active_int + active_frac/2^FRAC_WIDTH cycles. Each individual period is either active_int or active_int + 1 cycles.
- Tick outputs:
  - o_os_tick is registered and high for one cycle after each os event.
  - o_mid_tick is high with o_os_tick when the pre-increment os_cnt == OS_RATE/2 − 1.
  - o_bit_tick is high with o_os_tick when the pre-increment os_cnt == OS_RATE − 1.
- Divisor load:
  - i_div_load writes pend_int/pend_frac and sets pend_flag.
  - The pending values move to active, and pend_flag clears, at the first apply point: an os event edge, an i_clear edge, or any edge with i_en=0.
  - If i_div_load coincides with an apply point, the new input value goes straight to active.
  - The new divisor takes effect from the next period. The period in progress is never truncated or stretched.
  - frac_acc is not reset by a load.
- i_clear: cyc_cnt, os_cnt, frac_acc and ext ← 0. Pending values are applied. All ticks are low on the following cycle.
- Priority: reset > i_clear > i_en.
- o_div_err is registered as (active_int == 0). While it is high, counters are held at 0 and no ticks are produced. A later load with a nonzero value recovers normal operation.
- Reset values:
  - All outputs are 0.
  - Counters, frac_acc, ext and pend_flag are 0.
  - active_int = RESET_DIV_INT, active_frac = 0.

## Timing
- After an i_clear edge E0 with divisor N (N ≥ 1) and fraction 0:
  - o_os_tick is first high in the cycle after edge E0+N.
  - It then repeats every N cycles.
  - o_mid_tick falls on the (OS_RATE/2)th os tick; o_bit_tick on the OS_RATE-th.
- N=1 with fraction 0: o_os_tick is high on every cycle. An os event with fraction 0 never produces ext=1.
- Deasserting i_en freezes the phase exactly. On re-enable, counting resumes with the remaining cycles of the interrupted period.
- Load latency: the new divisor governs the period that starts after the apply edge. Worst case is one old period plus one cycle.
- Ticks are single-cycle pulses. Two consecutive high cycles occur only when the period is 1.

## Test plan
- Integer divide: N=4, frac=0, OS_RATE=16, clear, run 200 cycles.
  - o_os_tick every 4 cycles, first one 4 cycles after clear.
  - o_mid_tick at os tick 8, o_bit_tick at os tick 16 (cycle 64), repeating.
- Fractional divide: N=4, frac=8 (0.5), FRAC_WIDTH=4.
  - Periods after clear are 4,4,5,4,5,4,5…
  - 32 os ticks take exactly 144 cycles.
- Divisor change mid-period: N=10, then load N=3 at cyc_cnt=2.
  - The current period still completes in 10 cycles.
  - Every following period is 3 cycles.
  - Load with i_en=0 applies on the next edge.
- Enable freeze: drop i_en at cyc_cnt=5 of N=8 for 20 cycles.
  - No ticks while disabled.
  - The next tick comes 3 cycles after re-enable (cyc_cnt 5→7, then the event).
- Clear and load in the same cycle: i_clear together with i_div_load of N=6, while os_cnt=11.
  - os_cnt becomes 0 and N=6 is active immediately.
  - First tick 6 cycles later.
  - o_bit_tick on the 16th tick after the clear.
- Error and reset: load N=0.
  - o_div_err=1 after the apply edge; no ticks.
  - Reload N=2: o_div_err=0 and ticks every 2 cycles.
  - Async reset mid-period: all outputs drop to 0 immediately and active_int returns to RESET_DIV_INT.
